// File: rtl/uart_receiver.sv
// Receiver for the 7-bit serial link: start, parity, d0..d6, stop; one bit per CLKS_PER_BIT cycles.
// Define UART_RX_SYNC_EN to pass rx through a two-flop synchronizer (adds 2 cycles of latency).
module uart_receiver #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic       clk,
   input  logic       rstN,
   input  logic       rx,
   output logic [6:0] data,
   output logic       valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       busy
);

   localparam int HALF = (CLKS_PER_BIT - 1) / 2;
   localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [CW-1:0] CNT_RELOAD = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF   = CW'((HALF > 0) ? (HALF - 1) : 0);
   localparam bit HALF_ZERO = (HALF == 0);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      PARITY    = 3'd2,
      DATA      = 3'd3,
      STOP      = 3'd4,
      WAIT_IDLE = 3'd5
   } state_t;

   function automatic logic xor7(input logic [6:0] w);
      return ^w;
   endfunction

   state_t        state_r, state_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic [2:0]    idx_r, idx_s;
   logic [6:0]    shift_r, shift_s;
   logic          par_r, par_s;
   logic [6:0]    data_r, data_s;
   logic          valid_r, valid_s;
   logic          perr_r, perr_s;
   logic          ferr_r, ferr_s;
   logic          busy_r, busy_s;
   logic          rx_s;
   logic          sample_s;

`ifdef UART_RX_SYNC_EN
   logic sync1_r, sync2_r;

   // two-flop synchronizer, idles high like the line
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= rx;
         sync2_r <= sync1_r;
      end
   end

   assign rx_s = sync2_r;
`else
   assign rx_s = rx;
`endif

   assign sample_s = (cnt_r == CNT_ZERO);

   // next-state and output computation
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      idx_s   = idx_r;
      shift_s = shift_r;
      par_s   = par_r;
      data_s  = data_r;
      perr_s  = perr_r;
      ferr_s  = ferr_r;
      valid_s = 1'b0;
      busy_s  = busy_r;
      case (state_r)
         IDLE: begin
            if (!rx_s) begin
               busy_s = 1'b1;
               if (HALF_ZERO) begin
                  state_s = PARITY;
                  cnt_s   = CNT_RELOAD;
               end else begin
                  state_s = START;
                  cnt_s   = CNT_HALF;
               end
            end else begin
               busy_s = 1'b0;
            end
         end
         START: begin
            if (sample_s) begin
               if (rx_s) begin
                  state_s = IDLE;
                  busy_s  = 1'b0;
               end else begin
                  state_s = PARITY;
                  cnt_s   = CNT_RELOAD;
               end
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         PARITY: begin
            if (sample_s) begin
               par_s   = rx_s;
               idx_s   = 3'd0;
               state_s = DATA;
               cnt_s   = CNT_RELOAD;
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         DATA: begin
            if (sample_s) begin
               // LSB arrives first, so after seven right-shifts d0 sits at bit 0
               shift_s = {rx_s, shift_r[6:1]};
               cnt_s   = CNT_RELOAD;
               if (idx_r == 3'd6) begin
                  state_s = STOP;
               end else begin
                  idx_s = idx_r + 3'd1;
               end
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         STOP: begin
            if (sample_s) begin
               data_s  = shift_r;
               perr_s  = par_r ^ xor7(shift_r);
               ferr_s  = ~rx_s;
               valid_s = 1'b1;
               busy_s  = 1'b0;
               state_s = rx_s ? IDLE : WAIT_IDLE;
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         WAIT_IDLE: begin
            busy_s = 1'b0;
            if (rx_s) begin
               state_s = IDLE;
            end else begin
               state_s = WAIT_IDLE;
            end
         end
         default: begin
            state_s = IDLE;
            busy_s  = 1'b0;
         end
      endcase
   end

   // state and output registers
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_r <= IDLE;
         cnt_r   <= CNT_ZERO;
         idx_r   <= 3'd0;
         shift_r <= 7'd0;
         par_r   <= 1'b0;
         data_r  <= 7'd0;
         valid_r <= 1'b0;
         perr_r  <= 1'b0;
         ferr_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         idx_r   <= idx_s;
         shift_r <= shift_s;
         par_r   <= par_s;
         data_r  <= data_s;
         valid_r <= valid_s;
         perr_r  <= perr_s;
         ferr_r  <= ferr_s;
         busy_r  <= busy_s;
      end
   end

   assign data       = data_r;
   assign valid      = valid_r;
   assign parity_err = perr_r;
   assign frame_err  = ferr_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: one instance at 1 clk/bit, one at 4 clk/bit.
module tb_uart_receiver;

`ifdef UART_RX_SYNC_EN
   localparam int SL = 2;
`else
   localparam int SL = 0;
`endif

   typedef struct {
      logic [6:0] d;
      logic       pe;
      logic       fe;
      int         t;
   } exp_t;

   logic       clk = 1'b0;
   logic       rstN1, rstN4, rx1, rx4;
   logic [6:0] data1, data4;
   logic       valid1, valid4, perr1, perr4, ferr1, ferr4, busy1, busy4;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   busy_cnt1 = 0;
   int   busy_cnt4 = 0;
   int   b0;
   exp_t q1[$];
   exp_t q4[$];
   exp_t e1, e4;

   uart_receiver #(.CLKS_PER_BIT(1)) dut1 (
      .clk(clk), .rstN(rstN1), .rx(rx1), .data(data1), .valid(valid1),
      .parity_err(perr1), .frame_err(ferr1), .busy(busy1)
   );

   uart_receiver #(.CLKS_PER_BIT(4)) dut4 (
      .clk(clk), .rstN(rstN4), .rx(rx4), .data(data4), .valid(valid4),
      .parity_err(perr4), .frame_err(ferr4), .busy(busy4)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // output monitor: pops the scoreboard on every valid strobe
   always @(negedge clk) begin
      if (busy1) busy_cnt1++;
      if (busy4) busy_cnt4++;
      if (valid1) begin
         if (q1.size() == 0) begin
            check_eq("dut1_unexpected_valid", 1, 0);
         end else begin
            e1 = q1.pop_front();
            check_eq("dut1_data", int'(data1), int'(e1.d));
            check_eq("dut1_parity_err", int'(perr1), int'(e1.pe));
            check_eq("dut1_frame_err", int'(ferr1), int'(e1.fe));
            check_eq("dut1_valid_cycle", cyc, e1.t);
         end
      end
      if (valid4) begin
         if (q4.size() == 0) begin
            check_eq("dut4_unexpected_valid", 1, 0);
         end else begin
            e4 = q4.pop_front();
            check_eq("dut4_data", int'(data4), int'(e4.d));
            check_eq("dut4_parity_err", int'(perr4), int'(e4.pe));
            check_eq("dut4_frame_err", int'(ferr4), int'(e4.fe));
            check_eq("dut4_valid_cycle", cyc, e4.t);
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input int sel, input logic b, input int c);
      if (sel == 1) rx1 = b;
      else          rx4 = b;
      wait_cyc(c);
   endtask

   task automatic send_frame(input int sel, input logic [6:0] d, input logic par, input logic stop);
      int   c;
      exp_t e;
      c    = (sel == 1) ? 1 : 4;
      e.d  = d;
      e.pe = par ^ (^d);
      e.fe = ~stop;
      e.t  = cyc + 1 + (c - 1) / 2 + 9 * c + SL;
      if (sel == 1) q1.push_back(e);
      else          q4.push_back(e);
      drive_bit(sel, 1'b0, c);
      drive_bit(sel, par, c);
      for (int i = 0; i < 7; i++) drive_bit(sel, d[i], c);
      drive_bit(sel, stop, c);
   endtask

   initial begin
      rx1 = 1'b1;
      rx4 = 1'b1;
      rstN1 = 1'b0;
      rstN4 = 1'b0;
      wait_cyc(3);
      check_eq("reset_data1", int'(data1), 0);
      check_eq("reset_valid1", int'(valid1), 0);
      check_eq("reset_perr1", int'(perr1), 0);
      check_eq("reset_ferr1", int'(ferr1), 0);
      check_eq("reset_busy1", int'(busy1), 0);
      check_eq("reset_data4", int'(data4), 0);
      check_eq("reset_busy4", int'(busy4), 0);
      rstN1 = 1'b1;
      rstN4 = 1'b1;
      wait_cyc(3);

      // basic 0x55 frame and busy length
      b0 = busy_cnt1;
      send_frame(1, 7'h55, 1'b0, 1'b1);
      wait_cyc(4 + SL);
      check_eq("busy_len_55", busy_cnt1 - b0, 9);

      // back-to-back frames with a one-period stop
      send_frame(1, 7'h07, 1'b1, 1'b1);
      send_frame(1, 7'h40, 1'b1, 1'b1);
      wait_cyc(4 + SL);

      // parity error
      send_frame(1, 7'h55, 1'b1, 1'b1);
      wait_cyc(4 + SL);

      // framing error followed by a stuck-low line
      b0 = busy_cnt1;
      send_frame(1, 7'h2A, 1'b1, 1'b0);
      rx1 = 1'b0;
      wait_cyc(5);
      rx1 = 1'b1;
      wait_cyc(6 + SL);
      check_eq("busy_len_stuck_low", busy_cnt1 - b0, 9);
      check_eq("busy_after_stuck_low", int'(busy1), 0);

      // async reset during d3 of a 0x78 frame; remaining bits are all 1
      drive_bit(1, 1'b0, 1);
      drive_bit(1, 1'b0, 1);
      drive_bit(1, 1'b0, 1);
      drive_bit(1, 1'b0, 1);
      drive_bit(1, 1'b0, 1);
      rx1 = 1'b1;
      check_eq("busy_mid_frame", int'(busy1), 1);
      #1 rstN1 = 1'b0;
      #1;
      check_eq("midrst_data", int'(data1), 0);
      check_eq("midrst_valid", int'(valid1), 0);
      check_eq("midrst_perr", int'(perr1), 0);
      check_eq("midrst_ferr", int'(ferr1), 0);
      check_eq("midrst_busy", int'(busy1), 0);
      #1 rstN1 = 1'b1;
      wait_cyc(1);
      wait_cyc(4);
      wait_cyc(6);
      send_frame(1, 7'h11, 1'b0, 1'b1);
      wait_cyc(4 + SL);

      // 4 clk/bit: one-cycle glitch is rejected at the START check
      b0 = busy_cnt4;
      rx4 = 1'b0;
      wait_cyc(1);
      rx4 = 1'b1;
      wait_cyc(10);
      check_eq("glitch_busy_len", busy_cnt4 - b0, 1);
      check_eq("glitch_busy_after", int'(busy4), 0);

      send_frame(4, 7'h7F, 1'b1, 1'b1);
      wait_cyc(8 + SL);
      send_frame(4, 7'h2A, 1'b0, 1'b1);
      wait_cyc(8 + SL);

      check_eq("dut1_pending", q1.size(), 0);
      check_eq("dut4_pending", q4.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
